// File: rtl/sda_gmem_txn_tracker.sv
// Gmem AXI4 pass-through that caps outstanding read/write bursts, latches response errors,
// and holds the action's done handshake until every issued gmem transaction has retired.
module sda_gmem_txn_tracker #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int MAX_RD     = 8,
    parameter int MAX_WR     = 8
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    // action core side
    input  logic [ID_WIDTH-1:0]     s_gmem_AWID,
    input  logic [ADDR_WIDTH-1:0]   s_gmem_AWADDR,
    input  logic [7:0]              s_gmem_AWLEN,
    input  logic [2:0]              s_gmem_AWSIZE,
    input  logic [1:0]              s_gmem_AWBURST,
    input  logic                    s_gmem_AWLOCK,
    input  logic [3:0]              s_gmem_AWCACHE,
    input  logic [2:0]              s_gmem_AWPROT,
    input  logic [3:0]              s_gmem_AWQOS,
    input  logic                    s_gmem_AWVALID,
    output logic                    s_gmem_AWREADY,
    input  logic [DATA_WIDTH-1:0]   s_gmem_WDATA,
    input  logic [DATA_WIDTH/8-1:0] s_gmem_WSTRB,
    input  logic                    s_gmem_WLAST,
    input  logic                    s_gmem_WVALID,
    output logic                    s_gmem_WREADY,
    output logic [ID_WIDTH-1:0]     s_gmem_BID,
    output logic [1:0]              s_gmem_BRESP,
    output logic                    s_gmem_BVALID,
    input  logic                    s_gmem_BREADY,
    input  logic [ID_WIDTH-1:0]     s_gmem_ARID,
    input  logic [ADDR_WIDTH-1:0]   s_gmem_ARADDR,
    input  logic [7:0]              s_gmem_ARLEN,
    input  logic [2:0]              s_gmem_ARSIZE,
    input  logic [1:0]              s_gmem_ARBURST,
    input  logic                    s_gmem_ARLOCK,
    input  logic [3:0]              s_gmem_ARCACHE,
    input  logic [2:0]              s_gmem_ARPROT,
    input  logic [3:0]              s_gmem_ARQOS,
    input  logic                    s_gmem_ARVALID,
    output logic                    s_gmem_ARREADY,
    output logic [ID_WIDTH-1:0]     s_gmem_RID,
    output logic [DATA_WIDTH-1:0]   s_gmem_RDATA,
    output logic [1:0]              s_gmem_RRESP,
    output logic                    s_gmem_RLAST,
    output logic                    s_gmem_RVALID,
    input  logic                    s_gmem_RREADY,
    // platform side
    output logic [ID_WIDTH-1:0]     m_gmem_AWID,
    output logic [ADDR_WIDTH-1:0]   m_gmem_AWADDR,
    output logic [7:0]              m_gmem_AWLEN,
    output logic [2:0]              m_gmem_AWSIZE,
    output logic [1:0]              m_gmem_AWBURST,
    output logic                    m_gmem_AWLOCK,
    output logic [3:0]              m_gmem_AWCACHE,
    output logic [2:0]              m_gmem_AWPROT,
    output logic [3:0]              m_gmem_AWQOS,
    output logic                    m_gmem_AWVALID,
    input  logic                    m_gmem_AWREADY,
    output logic [DATA_WIDTH-1:0]   m_gmem_WDATA,
    output logic [DATA_WIDTH/8-1:0] m_gmem_WSTRB,
    output logic                    m_gmem_WLAST,
    output logic                    m_gmem_WVALID,
    input  logic                    m_gmem_WREADY,
    input  logic [ID_WIDTH-1:0]     m_gmem_BID,
    input  logic [1:0]              m_gmem_BRESP,
    input  logic                    m_gmem_BVALID,
    output logic                    m_gmem_BREADY,
    output logic [ID_WIDTH-1:0]     m_gmem_ARID,
    output logic [ADDR_WIDTH-1:0]   m_gmem_ARADDR,
    output logic [7:0]              m_gmem_ARLEN,
    output logic [2:0]              m_gmem_ARSIZE,
    output logic [1:0]              m_gmem_ARBURST,
    output logic                    m_gmem_ARLOCK,
    output logic [3:0]              m_gmem_ARCACHE,
    output logic [2:0]              m_gmem_ARPROT,
    output logic [3:0]              m_gmem_ARQOS,
    output logic                    m_gmem_ARVALID,
    input  logic                    m_gmem_ARREADY,
    input  logic [ID_WIDTH-1:0]     m_gmem_RID,
    input  logic [DATA_WIDTH-1:0]   m_gmem_RDATA,
    input  logic [1:0]              m_gmem_RRESP,
    input  logic                    m_gmem_RLAST,
    input  logic                    m_gmem_RVALID,
    output logic                    m_gmem_RREADY,
    // done handshake and status
    input  logic                    done_in_Ready,
    output logic                    done_in_Stop,
    output logic                    done_out_Ready,
    input  logic                    done_out_Stop,
    input  logic                    err_clear,
    output logic [3:0]              err_status,
    output logic                    idle
);

    localparam int RD_W = $clog2(MAX_RD + 1);
    localparam int WR_W = $clog2(MAX_WR + 1);
    localparam logic [RD_W-1:0] RD_LIMIT = RD_W'(MAX_RD);
    localparam logic [WR_W-1:0] WR_LIMIT = WR_W'(MAX_WR);

    typedef enum logic [1:0] {IDLE, DRAIN, PRESENT} doneState_e;

    logic [RD_W-1:0] rdCnt_q, rdCnt_d;
    logic [WR_W-1:0] wrCnt_q, wrCnt_d;
    logic [3:0]      errStatus_q, errStatus_d;
    doneState_e      doneState_q;
    logic            doneOutReady_q;
    logic            rdOpen, wrOpen, arHs, awHs, rBeatHs, rLastHs, bHs;

    assign m_gmem_AWID    = s_gmem_AWID;
    assign m_gmem_AWADDR  = s_gmem_AWADDR;
    assign m_gmem_AWLEN   = s_gmem_AWLEN;
    assign m_gmem_AWSIZE  = s_gmem_AWSIZE;
    assign m_gmem_AWBURST = s_gmem_AWBURST;
    assign m_gmem_AWLOCK  = s_gmem_AWLOCK;
    assign m_gmem_AWCACHE = s_gmem_AWCACHE;
    assign m_gmem_AWPROT  = s_gmem_AWPROT;
    assign m_gmem_AWQOS   = s_gmem_AWQOS;
    assign m_gmem_WDATA   = s_gmem_WDATA;
    assign m_gmem_WSTRB   = s_gmem_WSTRB;
    assign m_gmem_WLAST   = s_gmem_WLAST;
    assign m_gmem_WVALID  = s_gmem_WVALID;
    assign s_gmem_WREADY  = m_gmem_WREADY;
    assign s_gmem_BID     = m_gmem_BID;
    assign s_gmem_BRESP   = m_gmem_BRESP;
    assign s_gmem_BVALID  = m_gmem_BVALID;
    assign m_gmem_BREADY  = s_gmem_BREADY;
    assign m_gmem_ARID    = s_gmem_ARID;
    assign m_gmem_ARADDR  = s_gmem_ARADDR;
    assign m_gmem_ARLEN   = s_gmem_ARLEN;
    assign m_gmem_ARSIZE  = s_gmem_ARSIZE;
    assign m_gmem_ARBURST = s_gmem_ARBURST;
    assign m_gmem_ARLOCK  = s_gmem_ARLOCK;
    assign m_gmem_ARCACHE = s_gmem_ARCACHE;
    assign m_gmem_ARPROT  = s_gmem_ARPROT;
    assign m_gmem_ARQOS   = s_gmem_ARQOS;
    assign s_gmem_RID     = m_gmem_RID;
    assign s_gmem_RDATA   = m_gmem_RDATA;
    assign s_gmem_RRESP   = m_gmem_RRESP;
    assign s_gmem_RLAST   = m_gmem_RLAST;
    assign s_gmem_RVALID  = m_gmem_RVALID;
    assign m_gmem_RREADY  = s_gmem_RREADY;

    // Gates look only at the registered counts, so a retiring burst reopens them a cycle later.
    assign rdOpen         = rdCnt_q < RD_LIMIT;
    assign wrOpen         = wrCnt_q < WR_LIMIT;
    assign m_gmem_ARVALID = s_gmem_ARVALID & rdOpen;
    assign s_gmem_ARREADY = m_gmem_ARREADY & rdOpen;
    assign m_gmem_AWVALID = s_gmem_AWVALID & wrOpen;
    assign s_gmem_AWREADY = m_gmem_AWREADY & wrOpen;

    assign arHs    = m_gmem_ARVALID & m_gmem_ARREADY;
    assign awHs    = m_gmem_AWVALID & m_gmem_AWREADY;
    assign rBeatHs = m_gmem_RVALID & s_gmem_RREADY;
    assign rLastHs = rBeatHs & m_gmem_RLAST;
    assign bHs     = m_gmem_BVALID & s_gmem_BREADY;

    always_comb begin
        rdCnt_d = rdCnt_q;
        wrCnt_d = wrCnt_q;
        if (arHs && !rLastHs) begin
            rdCnt_d = rdCnt_q + RD_W'(1);
        end else if (!arHs && rLastHs && rdCnt_q != '0) begin
            rdCnt_d = rdCnt_q - RD_W'(1);
        end
        if (awHs && !bHs) begin
            wrCnt_d = wrCnt_q + WR_W'(1);
        end else if (!awHs && bHs && wrCnt_q != '0) begin
            wrCnt_d = wrCnt_q - WR_W'(1);
        end
        // A new error in the clearing cycle survives the clear.
        errStatus_d = (err_clear ? 4'b0000 : errStatus_q)
                    | {bHs & (wrCnt_q == '0), rLastHs & (rdCnt_q == '0),
                       bHs & (m_gmem_BRESP != 2'b00), rBeatHs & (m_gmem_RRESP != 2'b00)};
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rdCnt_q     <= '0;
            wrCnt_q     <= '0;
            errStatus_q <= 4'b0000;
        end else begin
            rdCnt_q     <= rdCnt_d;
            wrCnt_q     <= wrCnt_d;
            errStatus_q <= errStatus_d;
        end
    end

    assign idle       = (rdCnt_q == '0) && (wrCnt_q == '0);
    assign err_status = errStatus_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            doneState_q    <= IDLE;
            doneOutReady_q <= 1'b0;
        end else begin
            case (doneState_q)
                IDLE: begin
                    if (done_in_Ready) doneState_q <= DRAIN;
                end
                DRAIN: begin
                    if (idle) begin
                        doneState_q    <= PRESENT;
                        doneOutReady_q <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (!done_out_Stop) begin
                        doneState_q    <= IDLE;
                        doneOutReady_q <= 1'b0;
                    end
                end
                default: begin
                    doneState_q    <= IDLE;
                    doneOutReady_q <= 1'b0;
                end
            endcase
        end
    end

    // While presenting, the action sees the control block's backpressure so both sides transfer together.
    assign done_out_Ready = doneOutReady_q;
    assign done_in_Stop   = (doneState_q == PRESENT) ? done_out_Stop : 1'b1;

endmodule

// File: tb/tb_sda_gmem_txn_tracker.sv
// Self-checking bench: directed scenarios for limits, done draining, errors and reset,
// then randomized AXI traffic checked against an outstanding-count reference model.
module tb_sda_gmem_txn_tracker;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int IW = 1;
    localparam int MAX_RD = 3;
    localparam int MAX_WR = 2;

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    always #5 ap_clk = ~ap_clk;

    logic [IW-1:0] s_AWID, m_AWID, s_ARID, m_ARID, s_BID, m_BID, s_RID, m_RID;
    logic [AW-1:0] s_AWADDR, m_AWADDR, s_ARADDR, m_ARADDR;
    logic [7:0] s_AWLEN, m_AWLEN, s_ARLEN, m_ARLEN;
    logic [2:0] s_AWSIZE, m_AWSIZE, s_ARSIZE, m_ARSIZE, s_AWPROT, m_AWPROT, s_ARPROT, m_ARPROT;
    logic [1:0] s_AWBURST, m_AWBURST, s_ARBURST, m_ARBURST;
    logic s_AWLOCK, m_AWLOCK, s_ARLOCK, m_ARLOCK;
    logic [3:0] s_AWCACHE, m_AWCACHE, s_ARCACHE, m_ARCACHE, s_AWQOS, m_AWQOS, s_ARQOS, m_ARQOS;
    logic s_AWVALID, s_AWREADY, m_AWVALID, m_AWREADY, s_ARVALID, s_ARREADY, m_ARVALID, m_ARREADY;
    logic [DW-1:0] s_WDATA, m_WDATA, s_RDATA, m_RDATA;
    logic [DW/8-1:0] s_WSTRB, m_WSTRB;
    logic s_WLAST, m_WLAST, s_WVALID, m_WVALID, s_WREADY, m_WREADY;
    logic [1:0] s_BRESP, m_BRESP, s_RRESP, m_RRESP;
    logic s_BVALID, m_BVALID, s_BREADY, m_BREADY;
    logic s_RLAST, m_RLAST, s_RVALID, m_RVALID, s_RREADY, m_RREADY;
    logic done_in_Ready, done_in_Stop, done_out_Ready, done_out_Stop, err_clear, idle;
    logic [3:0] err_status;

    sda_gmem_txn_tracker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
                           .MAX_RD(MAX_RD), .MAX_WR(MAX_WR)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_gmem_AWID(s_AWID), .s_gmem_AWADDR(s_AWADDR), .s_gmem_AWLEN(s_AWLEN),
        .s_gmem_AWSIZE(s_AWSIZE), .s_gmem_AWBURST(s_AWBURST), .s_gmem_AWLOCK(s_AWLOCK),
        .s_gmem_AWCACHE(s_AWCACHE), .s_gmem_AWPROT(s_AWPROT), .s_gmem_AWQOS(s_AWQOS),
        .s_gmem_AWVALID(s_AWVALID), .s_gmem_AWREADY(s_AWREADY),
        .s_gmem_WDATA(s_WDATA), .s_gmem_WSTRB(s_WSTRB), .s_gmem_WLAST(s_WLAST),
        .s_gmem_WVALID(s_WVALID), .s_gmem_WREADY(s_WREADY),
        .s_gmem_BID(s_BID), .s_gmem_BRESP(s_BRESP), .s_gmem_BVALID(s_BVALID), .s_gmem_BREADY(s_BREADY),
        .s_gmem_ARID(s_ARID), .s_gmem_ARADDR(s_ARADDR), .s_gmem_ARLEN(s_ARLEN),
        .s_gmem_ARSIZE(s_ARSIZE), .s_gmem_ARBURST(s_ARBURST), .s_gmem_ARLOCK(s_ARLOCK),
        .s_gmem_ARCACHE(s_ARCACHE), .s_gmem_ARPROT(s_ARPROT), .s_gmem_ARQOS(s_ARQOS),
        .s_gmem_ARVALID(s_ARVALID), .s_gmem_ARREADY(s_ARREADY),
        .s_gmem_RID(s_RID), .s_gmem_RDATA(s_RDATA), .s_gmem_RRESP(s_RRESP), .s_gmem_RLAST(s_RLAST),
        .s_gmem_RVALID(s_RVALID), .s_gmem_RREADY(s_RREADY),
        .m_gmem_AWID(m_AWID), .m_gmem_AWADDR(m_AWADDR), .m_gmem_AWLEN(m_AWLEN),
        .m_gmem_AWSIZE(m_AWSIZE), .m_gmem_AWBURST(m_AWBURST), .m_gmem_AWLOCK(m_AWLOCK),
        .m_gmem_AWCACHE(m_AWCACHE), .m_gmem_AWPROT(m_AWPROT), .m_gmem_AWQOS(m_AWQOS),
        .m_gmem_AWVALID(m_AWVALID), .m_gmem_AWREADY(m_AWREADY),
        .m_gmem_WDATA(m_WDATA), .m_gmem_WSTRB(m_WSTRB), .m_gmem_WLAST(m_WLAST),
        .m_gmem_WVALID(m_WVALID), .m_gmem_WREADY(m_WREADY),
        .m_gmem_BID(m_BID), .m_gmem_BRESP(m_BRESP), .m_gmem_BVALID(m_BVALID), .m_gmem_BREADY(m_BREADY),
        .m_gmem_ARID(m_ARID), .m_gmem_ARADDR(m_ARADDR), .m_gmem_ARLEN(m_ARLEN),
        .m_gmem_ARSIZE(m_ARSIZE), .m_gmem_ARBURST(m_ARBURST), .m_gmem_ARLOCK(m_ARLOCK),
        .m_gmem_ARCACHE(m_ARCACHE), .m_gmem_ARPROT(m_ARPROT), .m_gmem_ARQOS(m_ARQOS),
        .m_gmem_ARVALID(m_ARVALID), .m_gmem_ARREADY(m_ARREADY),
        .m_gmem_RID(m_RID), .m_gmem_RDATA(m_RDATA), .m_gmem_RRESP(m_RRESP), .m_gmem_RLAST(m_RLAST),
        .m_gmem_RVALID(m_RVALID), .m_gmem_RREADY(m_RREADY),
        .done_in_Ready(done_in_Ready), .done_in_Stop(done_in_Stop),
        .done_out_Ready(done_out_Ready), .done_out_Stop(done_out_Stop),
        .err_clear(err_clear), .err_status(err_status), .idle(idle)
    );

    int checks = 0;
    int failures = 0;
    int rdOut, wrOut;
    logic [3:0] errModel;

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic clearInputs();
        {s_AWID, s_AWADDR, s_AWLEN, s_AWSIZE, s_AWBURST, s_AWLOCK, s_AWCACHE, s_AWPROT, s_AWQOS} = '0;
        {s_ARID, s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST, s_ARLOCK, s_ARCACHE, s_ARPROT, s_ARQOS} = '0;
        {s_AWVALID, s_ARVALID, s_WDATA, s_WSTRB, s_WLAST, s_WVALID, s_BREADY, s_RREADY} = '0;
        {m_AWREADY, m_ARREADY, m_WREADY, m_BID, m_BRESP, m_BVALID} = '0;
        {m_RID, m_RDATA, m_RRESP, m_RLAST, m_RVALID} = '0;
        {done_in_Ready, done_out_Stop, err_clear} = '0;
    endtask

    // Random traffic on both sides; response channels fire less often so counts build up.
    task automatic applyStimulus();
        s_ARADDR  = {$urandom, $urandom};
        s_AWADDR  = {$urandom, $urandom};
        s_ARLEN   = 8'($urandom);
        s_WDATA   = $urandom;
        s_WSTRB   = 4'($urandom);
        s_WVALID  = 1'($urandom);
        m_WREADY  = 1'($urandom);
        m_RDATA   = $urandom;
        s_ARVALID = 1'($urandom);
        m_ARREADY = 1'($urandom);
        s_AWVALID = 1'($urandom);
        m_AWREADY = 1'($urandom);
        m_RVALID  = ($urandom_range(0, 2) == 0);
        m_RLAST   = 1'($urandom);
        m_RRESP   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        s_RREADY  = 1'($urandom);
        m_BVALID  = ($urandom_range(0, 2) == 0);
        m_BRESP   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        s_BREADY  = 1'($urandom);
        err_clear = ($urandom_range(0, 5) == 0);
        done_out_Stop = 1'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit arHs, awHs, rBeat, rLast, bHs;
        logic [3:0] errSet;
        clearInputs();
        ap_rst_n = 1'b0;
        #3;
        checkOutput("rst_err", err_status, 4'b0000);
        checkOutput("rst_idle", idle, 1);
        checkOutput("rst_done_out", done_out_Ready, 0);
        checkOutput("rst_done_stop", done_in_Stop, 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step();
        step();
        checkOutput("post_rst_idle", idle, 1);
        checkOutput("post_rst_done_out", done_out_Ready, 0);
        checkOutput("post_rst_done_stop", done_in_Stop, 1);

        $display("[TB] read limit");
        s_ARVALID = 1; m_ARREADY = 1;
        for (int i = 0; i < MAX_RD; i++) begin
            #1 checkOutput("rdlim_open", m_ARVALID, 1);
            step();
        end
        #1 checkOutput("rdlim_closed_v", m_ARVALID, 0);
        checkOutput("rdlim_closed_r", s_ARREADY, 0);
        checkOutput("rdlim_busy", idle, 0);
        m_RVALID = 1; s_RREADY = 1; m_RLAST = 1;
        #1 checkOutput("rdlim_same_cycle", m_ARVALID, 0);
        step();
        m_RVALID = 0;
        #1 checkOutput("rdlim_reopen", m_ARVALID, 1);
        step();
        #1 checkOutput("rdlim_full_again", m_ARVALID, 0);
        s_ARVALID = 0;
        m_RVALID = 1;
        repeat (MAX_RD) step();
        m_RVALID = 0;
        checkOutput("rdlim_drained", idle, 1);
        checkOutput("rdlim_no_err", err_status, 4'b0000);

        $display("[TB] done drain");
        s_AWVALID = 1; m_AWREADY = 1;
        step();
        s_AWVALID = 0;
        done_in_Ready = 1; done_out_Stop = 1;
        step();
        checkOutput("drain_hold", done_out_Ready, 0);
        checkOutput("drain_stop", done_in_Stop, 1);
        step();
        checkOutput("drain_hold2", done_out_Ready, 0);
        m_BVALID = 1; s_BREADY = 1; m_BRESP = 2'b00;
        step();
        m_BVALID = 0;
        checkOutput("drain_idle", idle, 1);
        checkOutput("drain_b_plus1", done_out_Ready, 0);
        step();
        checkOutput("drain_b_plus2", done_out_Ready, 1);
        checkOutput("present_stop_follow1", done_in_Stop, 1);
        step();
        checkOutput("present_hold", done_out_Ready, 1);
        done_out_Stop = 0;
        #1 checkOutput("present_stop_follow0", done_in_Stop, 0);
        step();
        done_in_Ready = 0;
        checkOutput("done_complete", done_out_Ready, 0);
        checkOutput("done_back_stop", done_in_Stop, 1);
        step();
        step();
        checkOutput("done_stays_idle", done_out_Ready, 0);

        $display("[TB] errors");
        s_AWVALID = 1; m_AWREADY = 1;
        step();
        s_AWVALID = 0;
        m_BVALID = 1; s_BREADY = 1; m_BRESP = 2'b10;
        step();
        m_BVALID = 0; m_BRESP = 2'b00;
        checkOutput("err_bresp", err_status, 4'b0010);
        err_clear = 1; m_RVALID = 1; s_RREADY = 1; m_RLAST = 0; m_RRESP = 2'b11;
        step();
        err_clear = 0; m_RVALID = 0; m_RRESP = 2'b00;
        checkOutput("err_clear_vs_set", err_status, 4'b0001);
        m_BVALID = 1; s_BREADY = 1;
        step();
        m_BVALID = 0;
        checkOutput("err_b_underflow", err_status, 4'b1001);
        checkOutput("underflow_cnt_zero", idle, 1);
        err_clear = 1;
        step();
        err_clear = 0;
        checkOutput("err_cleared", err_status, 4'b0000);

        $display("[TB] reset mid-drain");
        s_ARVALID = 1; m_ARREADY = 1;
        repeat (3) step();
        s_ARVALID = 0;
        done_in_Ready = 1; done_out_Stop = 0;
        step();
        step();
        checkOutput("middrain_hold", done_out_Ready, 0);
        checkOutput("middrain_busy", idle, 0);
        #2 ap_rst_n = 0;
        #1 checkOutput("middrain_rst_idle", idle, 1);
        checkOutput("middrain_rst_done", done_out_Ready, 0);
        checkOutput("middrain_rst_stop", done_in_Stop, 1);
        done_in_Ready = 0;
        @(negedge ap_clk);
        ap_rst_n = 1;
        s_ARVALID = 1;
        #1 checkOutput("middrain_gate_open", m_ARVALID, 1);
        step();
        step();
        checkOutput("middrain_fsm_idle", done_out_Ready, 0);

        $display("[TB] random traffic");
        clearInputs();
        ap_rst_n = 0;
        #2 ap_rst_n = 1;
        @(negedge ap_clk);
        rdOut = 0; wrOut = 0; errModel = 4'b0000;
        for (int c = 0; c < 500; c++) begin
            applyStimulus();
            #1;
            checkOutput("rnd_arvalid", m_ARVALID, s_ARVALID && (rdOut < MAX_RD));
            checkOutput("rnd_arready", s_ARREADY, m_ARREADY && (rdOut < MAX_RD));
            checkOutput("rnd_awvalid", m_AWVALID, s_AWVALID && (wrOut < MAX_WR));
            checkOutput("rnd_awready", s_AWREADY, m_AWREADY && (wrOut < MAX_WR));
            checkOutput("rnd_araddr", m_ARADDR, s_ARADDR);
            checkOutput("rnd_wdata", {m_WDATA, m_WVALID, s_WREADY}, {s_WDATA, s_WVALID, m_WREADY});
            checkOutput("rnd_rpath", {s_RDATA, s_RVALID, m_RREADY}, {m_RDATA, m_RVALID, s_RREADY});
            checkOutput("rnd_done_stop", done_in_Stop, 1);
            arHs  = s_ARVALID && m_ARREADY && (rdOut < MAX_RD);
            awHs  = s_AWVALID && m_AWREADY && (wrOut < MAX_WR);
            rBeat = m_RVALID && s_RREADY;
            rLast = rBeat && m_RLAST;
            bHs   = m_BVALID && s_BREADY;
            errSet = {bHs && (wrOut == 0), rLast && (rdOut == 0),
                      bHs && (m_BRESP != 2'b00), rBeat && (m_RRESP != 2'b00)};
            step();
            rdOut = rdOut + int'(arHs) - int'(rLast);
            if (rdOut < 0) rdOut = 0;
            wrOut = wrOut + int'(awHs) - int'(bHs);
            if (wrOut < 0) wrOut = 0;
            errModel = (err_clear ? 4'b0000 : errModel) | errSet;
            checkOutput("rnd_idle", idle, (rdOut == 0) && (wrOut == 0));
            checkOutput("rnd_err", err_status, errModel);
            checkOutput("rnd_done_out", done_out_Ready, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
